// File: rtl/acc_mul_pkg.sv
// Shared definitions for the ACC_BUS multiply responder.
// Holds the instruction-field constants, the internal operation encoding and
// the response record that travels through the pipeline and response FIFO.
// The record widths match the responder's default DataWidth/IdWidth; change
// them together.
package acc_mul_pkg;

    localparam int RSP_DATA_W = 32;
    localparam int RSP_ID_W   = 5;

    localparam logic [6:0] OPCODE_OP      = 7'b0110011;
    localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;
    localparam logic [6:0] FUNCT7_MULDIV  = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_MULW2  = 3'b000;

    typedef enum logic [2:0] {
        OP_MUL,
        OP_MULH,
        OP_MULHSU,
        OP_MULHU,
        OP_MULW2,
        OP_ERR
    } op_e;

    typedef struct packed {
        logic [RSP_DATA_W-1:0] data0;
        logic [RSP_DATA_W-1:0] data1;
        logic                  dual;
        logic [RSP_ID_W-1:0]   id;
        logic                  error;
    } rsp_t;

endpackage

// File: rtl/acc_mul_pipe.sv
// Fixed-latency multiply pipeline.
// The product is formed combinationally at the input and then carried through
// Latency register stages, so synthesis is free to retime the multiplier
// across them. Unsupported ops travel as error records to keep ordering.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   valid_i             request enters the pipe this cycle
//   op_i                decoded operation
//   arga_i, argb_i      rs1 / rs2 operands
//   id_i                transaction ID
//   valid_o, rsp_o      record leaving the last stage
module acc_mul_pipe
    import acc_mul_pkg::*;
#(
    parameter int DataWidth = RSP_DATA_W,
    parameter int IdWidth   = RSP_ID_W,
    parameter int Latency   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  op_e                  op_i,
    input  logic [DataWidth-1:0] arga_i,
    input  logic [DataWidth-1:0] argb_i,
    input  logic [IdWidth-1:0]   id_i,
    output logic                 valid_o,
    output rsp_t                 rsp_o
);

    logic                        sign_a;
    logic                        sign_b;
    logic [DataWidth:0]          a_ext;
    logic [DataWidth:0]          b_ext;
    logic signed [2*DataWidth+1:0] prod;
    rsp_t                        rsp_d;

    logic [Latency-1:0]          vld_q;
    rsp_t                        rsp_q [Latency];

    always_comb begin
        sign_a = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_MULW2);
        sign_b = (op_i == OP_MULH) || (op_i == OP_MULW2);
    end

    // One extra bit per operand lets a single signed multiplier cover
    // signed, unsigned and mixed-sign operand pairs.
    assign a_ext = {sign_a & arga_i[DataWidth-1], arga_i};
    assign b_ext = {sign_b & argb_i[DataWidth-1], argb_i};
    assign prod  = $signed({{(DataWidth+1){a_ext[DataWidth]}}, a_ext})
                 * $signed({{(DataWidth+1){b_ext[DataWidth]}}, b_ext});

    always_comb begin
        rsp_d    = '0;
        rsp_d.id = id_i;
        case (op_i)
            OP_MUL:                      rsp_d.data0 = prod[DataWidth-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: rsp_d.data0 = prod[2*DataWidth-1:DataWidth];
            OP_MULW2: begin
                rsp_d.data0 = prod[DataWidth-1:0];
                rsp_d.data1 = prod[2*DataWidth-1:DataWidth];
                rsp_d.dual  = 1'b1;
            end
            default:                     rsp_d.error = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= valid_i;
            for (int i = 1; i < Latency; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Payload needs no reset: it is only observed alongside its valid bit.
    always_ff @(posedge clk_i) begin
        rsp_q[0] <= rsp_d;
        for (int i = 1; i < Latency; i++) begin
            rsp_q[i] <= rsp_q[i-1];
        end
    end

    assign valid_o = vld_q[Latency-1];
    assign rsp_o   = rsp_q[Latency-1];

    logic unused_prod_hi;
    assign unused_prod_hi = ^prod[2*DataWidth+1:2*DataWidth];

endmodule

// File: rtl/acc_mul_responder.sv
// ACC_BUS offload responder executing RV M-extension multiplies.
// Q-channel requests are decoded, run through a fixed-latency pipeline and
// returned on the P channel through an in-order response FIFO. Admission is
// credit based (pipeline + FIFO occupancy), so the FIFO never overflows.
// Optional feature macro ACC_MUL_DUAL_WB_EN enables custom-0 MULW2, which
// returns the full signed product on p_data0_o/p_data1_o.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   q_addr_i, q_data_op_i        target address, instruction word
//   q_data_arga/argb/argc_i      rs1 / rs2 / rs3 (rs3 unused)
//   q_id_i, q_valid_i, q_ready_o request ID and handshake
//   p_data0_o, p_data1_o         result low / high word
//   p_dual_writeback_o           p_data1_o carries data
//   p_id_o, p_error_o            echoed ID, unsupported op / address
//   p_valid_o, p_ready_i         response handshake
module acc_mul_responder
    import acc_mul_pkg::*;
#(
    parameter int DataWidth = RSP_DATA_W,
    parameter int AddrWidth = 2,
    parameter int IdWidth   = RSP_ID_W,
    parameter int AccAddr   = 0,
    parameter int Latency   = 2,
    parameter int FifoDepth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AddrWidth-1:0] q_addr_i,
    input  logic [31:0]          q_data_op_i,
    input  logic [DataWidth-1:0] q_data_arga_i,
    input  logic [DataWidth-1:0] q_data_argb_i,
    input  logic [DataWidth-1:0] q_data_argc_i,
    input  logic [IdWidth-1:0]   q_id_i,
    input  logic                 q_valid_i,
    output logic                 q_ready_o,
    output logic [DataWidth-1:0] p_data0_o,
    output logic [DataWidth-1:0] p_data1_o,
    output logic                 p_dual_writeback_o,
    output logic [IdWidth-1:0]   p_id_o,
    output logic                 p_error_o,
    output logic                 p_valid_o,
    input  logic                 p_ready_i
);

    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntW = $clog2(FifoDepth + 1);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            addr_hit;
    op_e             op_sel;

    logic            accept;
    logic            pop;
    logic            push;
    rsp_t            pipe_rsp;

    rsp_t            mem [FifoDepth];
    logic [PtrW-1:0] wr_q;
    logic [PtrW-1:0] rd_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] occ_q;
    logic            rdy_q;
    rsp_t            head;

    assign opcode   = q_data_op_i[6:0];
    assign funct3   = q_data_op_i[14:12];
    assign funct7   = q_data_op_i[31:25];
    assign addr_hit = (q_addr_i == AddrWidth'(AccAddr));

    always_comb begin
        op_sel = OP_ERR;
        if (addr_hit) begin
            if (opcode == OPCODE_OP && funct7 == FUNCT7_MULDIV) begin
                case (funct3)
                    F3_MUL:    op_sel = OP_MUL;
                    F3_MULH:   op_sel = OP_MULH;
                    F3_MULHSU: op_sel = OP_MULHSU;
                    F3_MULHU:  op_sel = OP_MULHU;
                    default:   op_sel = OP_ERR;
                endcase
            end
`ifdef ACC_MUL_DUAL_WB_EN
            else if (opcode == OPCODE_CUSTOM0 && funct3 == F3_MULW2) begin
                op_sel = OP_MULW2;
            end
`endif
        end
    end

    // q_ready_o depends only on registers; rdy_q holds it low during reset.
    assign q_ready_o = rdy_q && (occ_q < CntW'(FifoDepth));
    assign p_valid_o = (cnt_q != '0);
    assign accept    = q_valid_i && q_ready_o;
    assign pop       = p_valid_o && p_ready_i;

    acc_mul_pipe #(
        .DataWidth (DataWidth),
        .IdWidth   (IdWidth),
        .Latency   (Latency)
    ) u_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (accept),
        .op_i    (op_sel),
        .arga_i  (q_data_arga_i),
        .argb_i  (q_data_argb_i),
        .id_i    (q_id_i),
        .valid_o (push),
        .rsp_o   (pipe_rsp)
    );

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            occ_q <= '0;
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (push) wr_q <= ptr_inc(wr_q);
            if (pop)  rd_q <= ptr_inc(rd_q);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            // Occupancy counts requests from acceptance until their pop.
            case ({accept, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_q] <= pipe_rsp;
    end

    assign head = mem[rd_q];

    // Outputs are gated with p_valid_o so they read zero whenever idle.
    assign p_data0_o = p_valid_o ? head.data0 : '0;
    assign p_id_o    = p_valid_o ? head.id    : '0;
    assign p_error_o = p_valid_o & head.error;

`ifdef ACC_MUL_DUAL_WB_EN
    assign p_data1_o          = p_valid_o ? head.data1 : '0;
    assign p_dual_writeback_o = p_valid_o & head.dual;

    logic unused_in;
    assign unused_in = ^{q_data_argc_i, q_data_op_i[24:15], q_data_op_i[11:7]};
`else
    assign p_data1_o          = '0;
    assign p_dual_writeback_o = 1'b0;

    logic unused_in;
    assign unused_in = ^{q_data_argc_i, q_data_op_i[24:15], q_data_op_i[11:7],
                         head.data1, head.dual};
`endif

endmodule

// File: tb/tb_acc_mul_responder.sv
module tb_acc_mul_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  q_addr_i;
    logic [31:0] q_data_op_i;
    logic [31:0] q_data_arga_i;
    logic [31:0] q_data_argb_i;
    logic [31:0] q_data_argc_i;
    logic [4:0]  q_id_i;
    logic        q_valid_i;
    logic        q_ready_o;
    logic [31:0] p_data0_o;
    logic [31:0] p_data1_o;
    logic        p_dual_writeback_o;
    logic [4:0]  p_id_o;
    logic        p_error_o;
    logic        p_valid_o;
    logic        p_ready_i;

    always #5 clk_i = ~clk_i;

    acc_mul_responder dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .q_addr_i           (q_addr_i),
        .q_data_op_i        (q_data_op_i),
        .q_data_arga_i      (q_data_arga_i),
        .q_data_argb_i      (q_data_argb_i),
        .q_data_argc_i      (q_data_argc_i),
        .q_id_i             (q_id_i),
        .q_valid_i          (q_valid_i),
        .q_ready_o          (q_ready_o),
        .p_data0_o          (p_data0_o),
        .p_data1_o          (p_data1_o),
        .p_dual_writeback_o (p_dual_writeback_o),
        .p_id_o             (p_id_o),
        .p_error_o          (p_error_o),
        .p_valid_o          (p_valid_o),
        .p_ready_i          (p_ready_i)
    );

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  id;
    } req_t;

    typedef struct packed {
        logic [31:0] d0;
        logic [31:0] d1;
        logic        dual;
        logic [4:0]  id;
        logic        err;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    localparam logic [31:0] ENC_MUL   = 32'h02B50533;
    localparam logic [31:0] ENC_MULW2 = 32'h02B5050B;
    localparam logic [31:0] ENC_ADD   = 32'h00B50533;

    function automatic logic [31:0] enc_md(input logic [2:0] f3);
        return {7'b0000001, 5'd11, 5'd10, f3, 5'd10, 7'b0110011};
    endfunction

    // Reference: full-width products in 64-bit arithmetic, then pick the word.
    function automatic exp_t model(input req_t r);
        exp_t e;
        longint sa, sb_, ub;
        logic [63:0] p;
        e     = '0;
        e.id  = r.id;
        e.err = 1'b1;
        sa  = longint'($signed(r.a));
        sb_ = longint'($signed(r.b));
        ub  = longint'({32'b0, r.b});
        if (r.addr == 2'd0) begin
            if (r.op[6:0] == 7'b0110011 && r.op[31:25] == 7'b0000001 && r.op[14] == 1'b0) begin
                e.err = 1'b0;
                case (r.op[13:12])
                    2'd0: e.d0 = r.a * r.b;
                    2'd1: begin p = 64'(sa * sb_); e.d0 = p[63:32]; end
                    2'd2: begin p = 64'(sa * ub); e.d0 = p[63:32]; end
                    default: begin p = {32'b0, r.a} * {32'b0, r.b}; e.d0 = p[63:32]; end
                endcase
            end
`ifdef ACC_MUL_DUAL_WB_EN
            else if (r.op[6:0] == 7'b0001011 && r.op[14:12] == 3'b000) begin
                p      = 64'(sa * sb_);
                e.err  = 1'b0;
                e.d0   = p[31:0];
                e.d1   = p[63:32];
                e.dual = 1'b1;
            end
`endif
        end
        return e;
    endfunction

    function automatic string fmt(input exp_t e);
        return $sformatf("d0=%h d1=%h dual=%b id=%0d err=%b", e.d0, e.d1, e.dual, e.id, e.err);
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] corner [5];
        corner = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        if ($urandom_range(0, 9) < 3) return corner[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    function automatic req_t rand_req(input logic [4:0] id);
        req_t r;
        int   k;
        r.id   = id;
        r.addr = ($urandom_range(0, 9) < 8) ? 2'd0 : 2'($urandom_range(1, 3));
        r.a    = rand_operand();
        r.b    = rand_operand();
        k      = $urandom_range(0, 9);
        case (k)
            0, 1, 2, 3: r.op = {7'b0000001, 10'($urandom), 3'(k), 5'($urandom), 7'b0110011};
            4:          r.op = enc_md(3'b100);
            5:          r.op = enc_md(3'b110);
            6:          r.op = ENC_MULW2;
            7:          r.op = ENC_ADD;
            default:    r.op = $urandom;
        endcase
        return r;
    endfunction

    req_t idle_req = '{addr: 2'd0, op: 32'h0, a: 32'h0, b: 32'h0, id: 5'd0};

    // One clock cycle: drive at the falling edge, note handshakes, capture the
    // P channel, record accepted requests in the scoreboard.
    task automatic step(input req_t r, input logic qv, input logic pr,
                        output logic acc, output logic pop, output exp_t obs);
        @(negedge clk_i);
        q_addr_i      = r.addr;
        q_data_op_i   = r.op;
        q_data_arga_i = r.a;
        q_data_argb_i = r.b;
        q_data_argc_i = $urandom;
        q_id_i        = r.id;
        q_valid_i     = qv;
        p_ready_i     = pr;
        acc      = qv && q_ready_o;
        pop      = p_valid_o && pr;
        obs.d0   = p_data0_o;
        obs.d1   = p_data1_o;
        obs.dual = p_dual_writeback_o;
        obs.id   = p_id_o;
        obs.err  = p_error_o;
        if (acc) sb.push_back(model(r));
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        q_valid_i = 1'b1;
        p_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({q_ready_o, p_valid_o, p_data0_o, p_data1_o, p_dual_writeback_o, p_id_o, p_error_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b vld=%b d0=%h id=%0d err=%b required all zero",
                     q_ready_o, p_valid_o, p_data0_o, p_id_o, p_error_o);
        end
        q_valid_i = 1'b0;
        rst_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (q_ready_o !== 1'b1 || p_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got rdy=%b vld=%b required rdy=1 vld=0", q_ready_o, p_valid_o);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_directed();
        req_t        v [4];
        logic [31:0] want [4];
        logic        acc, pop, done;
        exp_t        obs, e;
        int          lat;
        v[0] = '{addr: 2'd0, op: ENC_MUL,         a: 32'h3,        b: 32'hFFFFFFFE, id: 5'd7};
        v[1] = '{addr: 2'd0, op: enc_md(3'b001), a: 32'h80000000, b: 32'h80000000, id: 5'd8};
        v[2] = '{addr: 2'd0, op: enc_md(3'b011), a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, id: 5'd9};
        v[3] = '{addr: 2'd0, op: enc_md(3'b010), a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, id: 5'd10};
        want = '{32'hFFFFFFFA, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        for (int k = 0; k < 4; k++) begin
            step(v[k], 1'b1, 1'b1, acc, pop, obs);
            checks++;
            if (acc !== 1'b1) begin
                failures++;
                $display("FAIL directed_accept[%0d] got %b required 1", k, acc);
            end
            done = 1'b0;
            lat  = 0;
            for (int c = 1; c <= 10 && !done; c++) begin
                step(idle_req, 1'b0, 1'b1, acc, pop, obs);
                if (pop) begin
                    done = 1'b1;
                    lat  = c;
                    if (sb.size() != 0) e = sb.pop_front();
                    checks++;
                    if (obs.d0 !== want[k] || obs.id !== v[k].id || obs.err !== 1'b0 || obs.dual !== 1'b0) begin
                        failures++;
                        $display("FAIL directed_result[%0d] got %s required d0=%h id=%0d err=0",
                                 k, fmt(obs), want[k], v[k].id);
                    end
                end
            end
            checks++;
            if (lat != 3) begin
                failures++;
                $display("FAIL directed_latency[%0d] got %0d cycles required 3", k, lat);
            end
        end
    endtask

    task automatic test_errors();
        req_t        v [4];
        logic [4:0]  want_id [4];
        logic        want_err [4];
        logic        acc, pop;
        exp_t        obs, e;
        int          sent, got;
        v[0] = '{addr: 2'd0, op: ENC_MUL,         a: 32'd6, b: 32'd7, id: 5'd1};
        v[1] = '{addr: 2'd0, op: enc_md(3'b100), a: 32'd6, b: 32'd7, id: 5'd2};
        v[2] = '{addr: 2'd1, op: ENC_MUL,         a: 32'd6, b: 32'd7, id: 5'd3};
        v[3] = '{addr: 2'd0, op: ENC_MUL,         a: 32'd5, b: 32'd5, id: 5'd4};
        want_id  = '{5'd1, 5'd2, 5'd3, 5'd4};
        want_err = '{1'b0, 1'b1, 1'b1, 1'b0};
        sent = 0;
        got  = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            step((sent < 4) ? v[sent] : idle_req, sent < 4, 1'b1, acc, pop, obs);
            if (acc) sent++;
            if (pop) begin
                e = (sb.size() != 0) ? sb.pop_front() : '0;
                checks++;
                if (obs !== e || obs.id !== want_id[got] || obs.err !== want_err[got]
                    || (obs.err && obs.d0 !== 32'h0)) begin
                    failures++;
                    $display("FAIL error_order[%0d] got %s required %s", got, fmt(obs), fmt(e));
                end
                got++;
            end
        end
        checks++;
        if (got != 4) begin
            failures++;
            $display("FAIL error_timeout got %0d responses required 4", got);
        end
    endtask

    task automatic test_back_to_back();
        req_t r [6];
        logic acc, pop;
        exp_t obs, e;
        int   sent, got;
        for (int k = 0; k < 6; k++) begin
            r[k] = rand_req(5'(20 + k));
            r[k].addr = 2'd0;
            r[k].op   = ENC_MUL;
        end
        sent = 0;
        got  = 0;
        for (int c = 0; c < 10; c++) begin
            step((sent < 6) ? r[sent] : idle_req, sent < 6, 1'b0, acc, pop, obs);
            if (acc) sent++;
        end
        checks++;
        if (sent != 4 || q_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL bp_credits got accepted=%0d rdy=%b required accepted=4 rdy=0", sent, q_ready_o);
        end
        checks++;
        if (p_valid_o !== 1'b1 || p_id_o !== r[0].id) begin
            failures++;
            $display("FAIL bp_hold got vld=%b id=%0d required vld=1 id=%0d", p_valid_o, p_id_o, r[0].id);
        end
        for (int c = 0; c < 60 && got < 6; c++) begin
            step((sent < 6) ? r[sent] : idle_req, sent < 6, 1'b1, acc, pop, obs);
            if (acc) begin
                checks++;
                if (got < 1) begin
                    failures++;
                    $display("FAIL bp_early_accept got accept before any pop required after a pop");
                end
                sent++;
            end
            if (pop) begin
                e = (sb.size() != 0) ? sb.pop_front() : '0;
                checks++;
                if (obs !== e || obs.id !== r[got].id) begin
                    failures++;
                    $display("FAIL bp_rsp[%0d] got %s required %s", got, fmt(obs), fmt(e));
                end
                got++;
            end
        end
        checks++;
        if (got != 6 || sent != 6) begin
            failures++;
            $display("FAIL bp_drain got sent=%0d rsp=%0d required 6 and 6", sent, got);
        end
    endtask

    task automatic test_random();
        localparam int N = 200;
        req_t r;
        logic acc, pop, qv, pr;
        exp_t obs, e;
        int   sent, got;
        sent = 0;
        got  = 0;
        r    = rand_req(5'd0);
        for (int c = 0; c < 5000 && got < N; c++) begin
            qv = (sent < N) && ($urandom_range(0, 9) < 7);
            pr = (sent >= N) || ($urandom_range(0, 9) < 6);
            step(r, qv, pr, acc, pop, obs);
            if (acc) begin
                sent++;
                r = rand_req(5'(sent));
            end
            if (pop) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL random_unexpected got %s required no response", fmt(obs));
                end else begin
                    e = sb.pop_front();
                    if (obs !== e) begin
                        failures++;
                        $display("FAIL random_rsp[%0d] got %s required %s", got, fmt(obs), fmt(e));
                    end
                end
                got++;
            end
        end
        checks++;
        if (got != N || sb.size() != 0) begin
            failures++;
            $display("FAIL random_timeout got %0d responses required %0d", got, N);
        end
    endtask

    task automatic test_mid_reset();
        req_t r;
        logic acc, pop;
        exp_t obs, e;
        int   sent, stale, got;
        sent = 0;
        for (int c = 0; c < 8 && sent < 4; c++) begin
            r = rand_req(5'(sent + 1));
            step(r, 1'b1, 1'b0, acc, pop, obs);
            if (acc) sent++;
        end
        rst_i = 1'b1;
        step(idle_req, 1'b0, 1'b0, acc, pop, obs);
        rst_i = 1'b0;
        sb.delete();
        checks++;
        if (p_valid_o !== 1'b0 || q_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL midrst_clear got vld=%b rdy=%b required 0 0", p_valid_o, q_ready_o);
        end
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            step(idle_req, 1'b0, 1'b1, acc, pop, obs);
            if (pop) stale++;
        end
        checks++;
        if (stale != 0) begin
            failures++;
            $display("FAIL midrst_stale got %0d responses required 0", stale);
        end
        r = '{addr: 2'd0, op: ENC_MUL, a: 32'd1234, b: 32'd5678, id: 5'd17};
        sent = 0;
        got  = 0;
        for (int c = 0; c < 20 && got < 1; c++) begin
            step(r, sent < 1, 1'b1, acc, pop, obs);
            if (acc) sent++;
            if (pop) begin
                e = (sb.size() != 0) ? sb.pop_front() : '0;
                checks++;
                if (obs.d0 !== 32'd7006652 || obs.id !== 5'd17 || obs !== e) begin
                    failures++;
                    $display("FAIL midrst_first got %s required d0=%h id=17", fmt(obs), 32'd7006652);
                end
                got++;
            end
        end
        checks++;
        if (got != 1) begin
            failures++;
            $display("FAIL midrst_timeout got %0d responses required 1", got);
        end
    endtask

    task automatic test_dual_wb();
        req_t r;
        logic acc, pop;
        exp_t obs, want;
        int   got, sent;
        r = '{addr: 2'd0, op: ENC_MULW2, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, id: 5'd30};
`ifdef ACC_MUL_DUAL_WB_EN
        want = '{d0: 32'h1, d1: 32'h0, dual: 1'b1, id: 5'd30, err: 1'b0};
`else
        want = '{d0: 32'h0, d1: 32'h0, dual: 1'b0, id: 5'd30, err: 1'b1};
`endif
        got  = 0;
        sent = 0;
        for (int c = 0; c < 20 && got < 1; c++) begin
            step(r, sent < 1, 1'b1, acc, pop, obs);
            if (acc) sent++;
            if (pop) begin
                if (sb.size() != 0) void'(sb.pop_front());
                checks++;
                if (obs !== want) begin
                    failures++;
                    $display("FAIL mulw2 got %s required %s", fmt(obs), fmt(want));
                end
                got++;
            end
        end
        checks++;
        if (got != 1) begin
            failures++;
            $display("FAIL mulw2_timeout got %0d responses required 1", got);
        end
    endtask

    initial begin
        rst_i         = 1'b1;
        q_addr_i      = '0;
        q_data_op_i   = '0;
        q_data_arga_i = '0;
        q_data_argb_i = '0;
        q_data_argc_i = '0;
        q_id_i        = '0;
        q_valid_i     = 1'b0;
        p_ready_i     = 1'b0;
        test_reset();
        test_directed();
        test_errors();
        test_back_to_back();
        test_random();
        test_mid_reset();
        test_dual_wb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
